// File: rtl/eth_tx_framer.sv
// ---------------------------------------------------------------------------
// eth_tx_framer
// RMII-side Ethernet frame transmitter. Takes payload bytes (destination MAC
// through end of data) on a valid/ready byte stream and emits one dibit per
// clock: 31 preamble dibits, the SFD dibit, the payload, the CRC-32 FCS, then
// an inter-frame gap during which no new frame is accepted.
//
// Optional feature: define ETH_TX_PAD_EN to zero-pad short payloads up to
// MIN_PAYLOAD bytes before the FCS. Without it, short frames go out unpadded.
//
// Ports
//   clk    : 50 MHz system clock, one dibit per cycle
//   rst_n  : asynchronous reset, active low
//   axiiv  : payload byte valid
//   axiid  : payload byte
//   axiil  : last payload byte of the frame (qualified by axiiv)
//   axiir  : ready; a byte moves on a cycle with axiiv && axiir
//   axiov  : TXEN, high for preamble/SFD/payload/pad/FCS dibits
//   axiod  : TXD dibit, byte bit pairs {b[2k], b[2k+1]} for k = 0..3
//   done   : one-cycle pulse on the first cycle after the last FCS dibit
//   err    : one-cycle pulse when the payload stream underruns
// ---------------------------------------------------------------------------
module eth_tx_framer #(
  parameter int IFG_DIBITS  = 48,
  parameter int MIN_PAYLOAD = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       axiiv,
  input  logic [7:0] axiid,
  input  logic       axiil,
  output logic       axiir,
  output logic       axiov,
  output logic [1:0] axiod,
  output logic       done,
  output logic       err
);

  if (IFG_DIBITS < 1 || MIN_PAYLOAD < 1) begin : g_param_check
    $error("eth_tx_framer: IFG_DIBITS and MIN_PAYLOAD must be >= 1");
  end

`ifdef ETH_TX_PAD_EN
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_SFD, S_DATA, S_FCS, S_IFG, S_PAD} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_SFD, S_DATA, S_FCS, S_IFG} state_t;
`endif

  // Dibit counter must reach 30 (preamble) and IFG_DIBITS-1 (gap).
  localparam int CW = $clog2(IFG_DIBITS > 32 ? IFG_DIBITS : 32);

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r >> 1) ^ ({32{r[0] ^ d[i]}} & 32'hEDB8_8320);
    end
    return r;
  endfunction

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    sh_q, sh_d;       // dibit shifter: payload byte or ~CRC
  logic [31:0]    crc_q, crc_d;
  logic           last_q, last_d;
  logic           axiir_q, axiir_d;
  logic           axiov_q, axiov_d;
  logic [1:0]     axiod_q, axiod_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           take;
`ifdef ETH_TX_PAD_EN
  logic [10:0]    bcnt_q, bcnt_d;
  logic [10:0]    bcnt_inc;
  assign bcnt_inc = (bcnt_q == 11'h7FF) ? bcnt_q : bcnt_q + 11'd1;
`endif

  assign take = axiiv & axiir_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    sh_d    = sh_q;
    crc_d   = crc_q;
    last_d  = last_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef ETH_TX_PAD_EN
    bcnt_d  = bcnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (take) begin
          state_d = S_PRE;
          sh_d    = {24'd0, axiid};
          last_d  = axiil;
          crc_d   = crc_byte(32'hFFFF_FFFF, axiid);
`ifdef ETH_TX_PAD_EN
          bcnt_d  = 11'd1;
`endif
        end
      end
      S_PRE: begin
        if (cnt_q == CW'(30)) begin
          state_d = S_SFD;
          cnt_d   = '0;
        end
      end
      S_SFD: begin
        state_d = S_DATA;
        cnt_d   = '0;
      end
      S_DATA: begin
        sh_d = {2'b00, sh_q[31:2]};
        if (cnt_q == CW'(3)) begin
          cnt_d = '0;
          if (last_q) begin
`ifdef ETH_TX_PAD_EN
            if (bcnt_q < 11'(MIN_PAYLOAD)) begin
              state_d = S_PAD;
              sh_d    = '0;
              crc_d   = crc_byte(crc_q, 8'h00);
              bcnt_d  = bcnt_inc;
            end else
`endif
            begin
              state_d = S_FCS;
              sh_d    = ~crc_q;
            end
          end else if (take) begin
            // Next byte loads directly behind the current one: no bubble.
            sh_d   = {24'd0, axiid};
            last_d = axiil;
            crc_d  = crc_byte(crc_q, axiid);
`ifdef ETH_TX_PAD_EN
            bcnt_d = bcnt_inc;
`endif
          end else begin
            // Underrun: abandon the frame without an FCS.
            state_d = S_IFG;
            err_d   = 1'b1;
          end
        end
      end
`ifdef ETH_TX_PAD_EN
      S_PAD: begin
        if (cnt_q == CW'(3)) begin
          cnt_d = '0;
          if (bcnt_q >= 11'(MIN_PAYLOAD)) begin
            state_d = S_FCS;
            sh_d    = ~crc_q;
          end else begin
            crc_d  = crc_byte(crc_q, 8'h00);
            bcnt_d = bcnt_inc;
          end
        end
      end
`endif
      S_FCS: begin
        sh_d = {2'b00, sh_q[31:2]};
        if (cnt_q == CW'(15)) begin
          state_d = S_IFG;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      S_IFG: begin
        if (cnt_q == CW'(IFG_DIBITS - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered copies of what the next state presents.
    axiov_d = (state_d != S_IDLE) && (state_d != S_IFG);
    case (state_d)
      S_PRE:   axiod_d = 2'b10;
      S_SFD:   axiod_d = 2'b11;
      S_IDLE,
      S_IFG:   axiod_d = 2'b00;
      default: axiod_d = {sh_d[0], sh_d[1]};
    endcase
    axiir_d = (state_d == S_IDLE) ||
              ((state_d == S_DATA) && (cnt_d == CW'(3)) && !last_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      crc_q   <= 32'hFFFF_FFFF;
      last_q  <= 1'b0;
      axiir_q <= 1'b1;
      axiov_q <= 1'b0;
      axiod_q <= 2'b00;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef ETH_TX_PAD_EN
      bcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      crc_q   <= crc_d;
      last_q  <= last_d;
      axiir_q <= axiir_d;
      axiov_q <= axiov_d;
      axiod_q <= axiod_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef ETH_TX_PAD_EN
      bcnt_q  <= bcnt_d;
`endif
    end
  end

  assign axiir = axiir_q;
  assign axiov = axiov_q;
  assign axiod = axiod_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_eth_tx_framer.sv
// ---------------------------------------------------------------------------
// tb_eth_tx_framer
// Self-checking bench for eth_tx_framer. A negedge monitor records every
// transmitted dibit, frame boundaries, gap lengths and done/err pulses. The
// expected dibit stream of each frame is rebuilt from the byte list with a
// table-driven CRC-32 and compared against what the monitor saw.
// ---------------------------------------------------------------------------
module tb_eth_tx_framer;
  localparam int IFG  = 48;
  localparam int MINP = 60;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       axiiv = 1'b0;
  logic [7:0] axiid = 8'h00;
  logic       axiil = 1'b0;
  logic       axiir, axiov, done, err;
  logic [1:0] axiod;

  eth_tx_framer #(.IFG_DIBITS(IFG), .MIN_PAYLOAD(MINP)) dut (
    .clk(clk), .rst_n(rst_n), .axiiv(axiiv), .axiid(axiid), .axiil(axiil),
    .axiir(axiir), .axiov(axiov), .axiod(axiod), .done(done), .err(err)
  );

  always #10 clk = ~clk;

  int asserts = 0;
  int fails   = 0;

  // ---------------- monitor ----------------
  int         cyc = 0;
  bit         prev_ov = 1'b0;
  bit         in_gap = 1'b0;
  int         gap_run = 0;
  int         cur_len = 0;
  logic [1:0] obs[$];
  int         flen_q[$], fstart_q[$], fend_q[$], gap_q[$], done_q[$], err_q[$];

  always @(negedge clk) begin
    cyc++;
    if (axiov) begin
      obs.push_back(axiod);
      if (!prev_ov) begin
        fstart_q.push_back(cyc);
        cur_len = 0;
      end
      cur_len++;
    end else if (prev_ov) begin
      flen_q.push_back(cur_len);
      fend_q.push_back(cyc - 1);
      in_gap  = 1'b1;
      gap_run = 0;
    end
    if (in_gap) begin
      if (axiir) begin
        gap_q.push_back(gap_run);
        in_gap = 1'b0;
      end else if (!axiov) begin
        gap_run++;
      end
    end
    if (done) done_q.push_back(cyc);
    if (err)  err_q.push_back(cyc);
    prev_ov = axiov;
  end

  // ---------------- reference model ----------------
  logic [31:0] crc_tab [256];
  logic [1:0]  exp_q[$];

  function automatic logic [31:0] ref_fcs(input logic [7:0] bq[$]);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (bq[i]) c = crc_tab[c[7:0] ^ bq[i]] ^ (c >> 8);
    return ~c;
  endfunction

  task automatic add_byte(input logic [7:0] b);
    for (int k = 0; k < 4; k++)
      exp_q.push_back(2'(((b >> (2 * k)) & 1) * 2 + ((b >> (2 * k + 1)) & 1)));
  endtask

  task automatic build_exp(input logic [7:0] bq[$], input int u);
    logic [7:0]  fb[$];
    logic [31:0] fcs;
    exp_q.delete();
    repeat (31) exp_q.push_back(2'b10);
    exp_q.push_back(2'b11);
    if (u >= 0) begin
      for (int i = 0; i < u; i++) add_byte(bq[i]);
    end else begin
      fb = bq;
`ifdef ETH_TX_PAD_EN
      while (fb.size() < MINP) fb.push_back(8'h00);
`endif
      foreach (fb[i]) add_byte(fb[i]);
      fcs = ref_fcs(fb);
      for (int k = 0; k < 4; k++) add_byte(8'((fcs >> (8 * k)) & 32'hFF));
    end
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string nm, input longint act, input longint expv);
    asserts++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endtask

  task automatic drive(input logic [7:0] bq[$], input int u);
    int idx = 0;
    int n   = bq.size();
    bit fin = 1'b0;
    for (int t = 0; t < 1000 && !fin; t++) begin
      @(negedge clk);
      if (idx == n) begin
        axiiv = 1'b0; axiil = 1'b0; fin = 1'b1;
      end else if (axiir) begin
        if (idx == u) begin
          axiiv = 1'b0; axiil = 1'b0; fin = 1'b1;
        end else begin
          axiiv = 1'b1; axiid = bq[idx]; axiil = (idx == n - 1); idx++;
        end
      end else if (idx == 0) begin
        axiiv = 1'b1; axiid = bq[0]; axiil = (n == 1);
      end else begin
        // Junk while not ready: must be ignored.
        axiiv = 1'($urandom_range(0, 1));
        axiid = 8'($urandom);
        axiil = 1'($urandom_range(0, 1));
      end
    end
    if (!fin) check("drive_timeout", 0, 1);
  endtask

  task automatic wait_gaps(input int target);
    for (int t = 0; t < 3000 && gap_q.size() < target; t++) @(negedge clk);
    if (gap_q.size() < target) check("frame_timeout", gap_q.size(), target);
  endtask

  // Compares frame number fi (dibits starting at obs[ob0]) and gap gi.
  task automatic verify(input string nm, input logic [7:0] bq[$], input int u,
                        input int ob0, input int fi, input int gi);
    int mm = 0;
    int nd = 0;
    int ne = 0;
    int fend;
    build_exp(bq, u);
    if (flen_q.size() <= fi || gap_q.size() <= gi) begin
      check({nm, "_missing"}, flen_q.size(), fi + 1);
      return;
    end
    fend = fend_q[fi];
    for (int i = 0; i < exp_q.size(); i++)
      if (ob0 + i >= obs.size() || obs[ob0 + i] !== exp_q[i]) mm++;
    check({nm, "_len"}, flen_q[fi], exp_q.size());
    check({nm, "_dibit_mismatches"}, mm, 0);
    check({nm, "_gap"}, gap_q[gi], IFG);
    foreach (done_q[j]) if (done_q[j] >= fstart_q[fi] && done_q[j] <= fend + IFG + 1) begin
      nd++;
      check({nm, "_done_cycle"}, done_q[j], fend + 1);
    end
    foreach (err_q[j]) if (err_q[j] >= fstart_q[fi] && err_q[j] <= fend + IFG + 1) begin
      ne++;
      check({nm, "_err_cycle"}, err_q[j], fend + 1);
    end
    check({nm, "_done_count"}, nd, (u < 0) ? 1 : 0);
    check({nm, "_err_count"}, ne, (u < 0) ? 0 : 1);
    $display("frame %s: %0d bytes, underrun_at=%0d, txen_cycles=%0d, dibit_mismatches=%0d",
             nm, bq.size(), u, flen_q[fi], mm);
  endtask

  task automatic run_frame(input string nm, input logic [7:0] bq[$], input int u,
                           output int ob0, output int fi);
    int gi;
    ob0 = obs.size(); fi = flen_q.size(); gi = gap_q.size();
    drive(bq, u);
    wait_gaps(gi + 1);
    verify(nm, bq, u, ob0, fi, gi);
  endtask

  function automatic void rand_bytes(output logic [7:0] bq[$], input int n);
    bq.delete();
    for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    int n;
    int u;
    int exp_ov;
  } vec_t;

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t        tbl[7];
    logic [7:0]  bq[$];
    logic [7:0]  bq2[$];
    logic [31:0] w;
    int          ob0, fi, gi, ob1, n, u, padlen;

    for (int i = 0; i < 256; i++) begin
      logic [31:0] c;
      c = 32'(i);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      crc_tab[i] = c;
    end

`ifdef ETH_TX_PAD_EN
    padlen = 288;
`else
    padlen = 0;
`endif
    tbl[0] = '{1,  -1, (padlen != 0) ? padlen : 52};
    tbl[1] = '{2,  -1, (padlen != 0) ? padlen : 56};
    tbl[2] = '{5,  -1, (padlen != 0) ? padlen : 68};
    tbl[3] = '{20, -1, (padlen != 0) ? padlen : 128};
    tbl[4] = '{64, -1, 304};
    tbl[5] = '{8,   3, 44};
    tbl[6] = '{4,   1, 36};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_axiir", axiir, 1);
    check("rst_axiov", axiov, 0);
    check("rst_axiod", axiod, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;

    // T1: reset mid-preamble
    @(negedge clk);
    axiiv = 1'b1; axiid = 8'h5A; axiil = 1'b0;
    @(negedge clk);
    axiiv = 1'b0;
    repeat (10) @(negedge clk);
    check("t1_preamble_active", axiov, 1);
    #3 rst_n = 1'b0;
    #1;
    check("t1_axiov_async", axiov, 0);
    check("t1_axiir_async", axiir, 1);
    check("t1_axiod_async", axiod, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t1_idle_ready", axiir, 1);

    // T2: "123456789"
    bq = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    run_frame("t2_123456789", bq, -1, ob0, fi);
`ifndef ETH_TX_PAD_EN
    check("t2_txen_cycles", (flen_q.size() > fi) ? flen_q[fi] : -1, 84);
    w = 32'h0;
    for (int i = 0; i < 16; i++)
      if (ob0 + 68 + i < obs.size())
        w = w | (32'(obs[ob0 + 68 + i][1]) << (2 * i)) | (32'(obs[ob0 + 68 + i][0]) << (2 * i + 1));
    check("t2_fcs_word", w, 32'hCBF4_3926);
`endif

    // Table-driven frames
    for (int i = 0; i < 7; i++) begin
      rand_bytes(bq, tbl[i].n);
      run_frame($sformatf("tbl%0d", i), bq, tbl[i].u, ob0, fi);
      check($sformatf("tbl%0d_txen_cycles", i), (flen_q.size() > fi) ? flen_q[fi] : -1, tbl[i].exp_ov);
    end

    // T6: single byte 0xAB
    bq = '{8'hAB};
    run_frame("t6_single_ab", bq, -1, ob0, fi);
    if (ob0 + 36 <= obs.size())
      check("t6_payload_dibits", {obs[ob0 + 32], obs[ob0 + 33], obs[ob0 + 34], obs[ob0 + 35]}, 8'hD5);
    else
      check("t6_payload_dibits", obs.size(), ob0 + 36);

    // T3: back-to-back, second frame offered during the gap
    rand_bytes(bq, 6);
    rand_bytes(bq2, 3);
    ob0 = obs.size(); fi = flen_q.size(); gi = gap_q.size();
    drive(bq, -1);
    drive(bq2, -1);
    wait_gaps(gi + 2);
    verify("t3_first", bq, -1, ob0, fi, gi);
    ob1 = ob0 + exp_q.size();
    verify("t3_second", bq2, -1, ob1, fi + 1, gi + 1);
    if (fstart_q.size() > fi + 1)
      check("t3_restart_spacing", fstart_q[fi + 1] - fend_q[fi], IFG + 2);

`ifdef ETH_TX_PAD_EN
    // T5: 14-byte payload padded to 60
    rand_bytes(bq, 14);
    run_frame("t5_pad14", bq, -1, ob0, fi);
    check("t5_txen_cycles", (flen_q.size() > fi) ? flen_q[fi] : -1, 288);
`endif

    // Randomized frames against the model
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 70);
      u = ($urandom_range(0, 3) == 0 && n > 1) ? $urandom_range(1, n - 1) : -1;
      rand_bytes(bq, n);
      run_frame($sformatf("rand%0d", r), bq, u, ob0, fi);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
